// File: rtl/viterbi_ber_pkg.sv
// rtl/viterbi_ber_pkg.sv - shared types and default constants for the Viterbi BER checker
// Contents: ber_state_t (SEARCH / LOCKED) and default parameter values.
package viterbi_ber_pkg;

   typedef enum logic {ST_SEARCH, ST_LOCKED} ber_state_t;

   localparam int DEF_HIST_DEPTH = 64;
   localparam int DEF_SYNC_LEN   = 16;
   localparam int DEF_WIN_LEN    = 64;
   localparam int DEF_LOSS_THR   = 8;
   localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/ber_history.sv
// rtl/ber_history.sv - transmit-bit history shift register with indexed read and fill count
// Ports: clk, rst (sync, active-high), shift_en/shift_bit (push a new bit into hist[0]),
//        rd_idx/rd_bit (combinational read of hist[rd_idx], pre-shift),
//        fill (number of accepted bits, saturating at DEPTH).
module ber_history #(
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       shift_en,
   input  logic                       shift_bit,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic                       rd_bit,
   output logic [$clog2(DEPTH+1)-1:0] fill
);

   localparam int FW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
      end else if (shift_en) begin
         hist <= {hist[DEPTH-2:0], shift_bit};
         if (fill != FW'(DEPTH)) begin
            fill <= fill + FW'(1);
         end
      end
   end

   // Read sees the registered contents, i.e. the history before this cycle's shift.
   assign rd_bit = hist[rd_idx];

endmodule

// File: rtl/viterbi_ber_checker.sv
// rtl/viterbi_ber_checker.sv - latency search, lock tracking and BER statistics for the Viterbi loop
// Ports: clk, rst (sync, active-high); tx_bit_i/tx_valid_i (encoder input);
//        rx_bit_i/rx_valid_i (decoder output); chan_err_i (channel XOR mask);
//        clear_i (zero statistics, lock kept); locked_o, latency_o (alignment);
//        bit_ct_o, err_ct_o (locked compares / mismatches); chan_err_ct_o (injected errors).
module viterbi_ber_checker
   import viterbi_ber_pkg::*;
#(
   parameter int HIST_DEPTH = DEF_HIST_DEPTH,
   parameter int SYNC_LEN   = DEF_SYNC_LEN,
   parameter int WIN_LEN    = DEF_WIN_LEN,
   parameter int LOSS_THR   = DEF_LOSS_THR,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_bit_i,
   input  logic                          tx_valid_i,
   input  logic                          rx_bit_i,
   input  logic                          rx_valid_i,
   input  logic [1:0]                    chan_err_i,
   input  logic                          clear_i,
   output logic                          locked_o,
   output logic [$clog2(HIST_DEPTH)-1:0] latency_o,
   output logic [CNT_W-1:0]              bit_ct_o,
   output logic [CNT_W-1:0]              err_ct_o,
   output logic [CNT_W-1:0]              chan_err_ct_o
);

   localparam int AW  = $clog2(HIST_DEPTH);
   localparam int FW  = $clog2(HIST_DEPTH + 1);
   localparam int RW  = $clog2(SYNC_LEN + 1);
   localparam int WBW = $clog2(WIN_LEN + 1);
   localparam int WEW = $clog2(LOSS_THR + 1);

   ber_state_t     state_q, state_d;
   logic [AW-1:0]  cand_q, cand_d;
   logic [AW-1:0]  lat_q, lat_d;
   logic [RW-1:0]  run_q, run_d;
   logic [WBW-1:0] wbits_q, wbits_d;
   logic [WEW-1:0] werrs_q, werrs_d;
   logic [CNT_W-1:0] bit_q, bit_d, err_q, err_d, chan_q, chan_d;

   logic          hist_bit;
   logic [FW-1:0] fill;
   logic [AW-1:0] rd_idx;
   logic          hit;
   logic          bit_inc, err_inc;
   logic [1:0]    chan_pop;

   // Saturating add: the counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   assign rd_idx = (state_q == ST_LOCKED) ? lat_q : cand_q;

   ber_history #(.DEPTH(HIST_DEPTH)) u_hist (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (tx_valid_i),
      .shift_bit (tx_bit_i),
      .rd_idx    (rd_idx),
      .rd_bit    (hist_bit),
      .fill      (fill)
   );

   assign hit      = (rx_bit_i == hist_bit);
   assign chan_pop = {1'b0, chan_err_i[1]} + {1'b0, chan_err_i[0]};

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      lat_d   = lat_q;
      run_d   = run_q;
      wbits_d = wbits_q;
      werrs_d = werrs_q;
      bit_inc = 1'b0;
      err_inc = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            // A candidate is only judged once the history is deep enough to hold it.
            if (rx_valid_i && (fill > FW'(cand_q))) begin
               if (hit) begin
                  if (run_q == RW'(SYNC_LEN - 1)) begin
                     state_d = ST_LOCKED;
                     lat_d   = cand_q;
                     run_d   = '0;
                     wbits_d = '0;
                     werrs_d = '0;
                  end else begin
                     run_d = run_q + RW'(1);
                  end
               end else begin
                  run_d  = '0;
                  cand_d = (cand_q == AW'(HIST_DEPTH - 1)) ? '0 : cand_q + AW'(1);
               end
            end
         end
         ST_LOCKED: begin
            if (rx_valid_i) begin
               bit_inc = 1'b1;
               err_inc = !hit;
               if (!hit && (werrs_q == WEW'(LOSS_THR - 1))) begin
                  // Resume the search at the last good latency so a transient burst relocks fast.
                  state_d = ST_SEARCH;
                  cand_d  = lat_q;
                  run_d   = '0;
                  wbits_d = '0;
                  werrs_d = '0;
               end else if (wbits_q == WBW'(WIN_LEN - 1)) begin
                  wbits_d = '0;
                  werrs_d = '0;
               end else begin
                  wbits_d = wbits_q + WBW'(1);
                  werrs_d = werrs_q + WEW'(err_inc);
               end
            end
         end
         default: state_d = ST_SEARCH;
      endcase
      bit_d  = clear_i ? '0 : sat_add(bit_q, {1'b0, bit_inc});
      err_d  = clear_i ? '0 : sat_add(err_q, {1'b0, err_inc});
      chan_d = clear_i ? '0 : sat_add(chan_q, chan_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_SEARCH;
         cand_q  <= '0;
         lat_q   <= '0;
         run_q   <= '0;
         wbits_q <= '0;
         werrs_q <= '0;
         bit_q   <= '0;
         err_q   <= '0;
         chan_q  <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         lat_q   <= lat_d;
         run_q   <= run_d;
         wbits_q <= wbits_d;
         werrs_q <= werrs_d;
         bit_q   <= bit_d;
         err_q   <= err_d;
         chan_q  <= chan_d;
      end
   end

   assign locked_o      = (state_q == ST_LOCKED);
   assign latency_o     = lat_q;
   assign bit_ct_o      = bit_q;
   assign err_ct_o      = err_q;
   assign chan_err_ct_o = chan_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb/tb_viterbi_ber_checker.sv - directed self-checking bench for viterbi_ber_checker
module tb_viterbi_ber_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, tx_bit, tx_valid, rx_bit, rx_valid, clear;
   logic [1:0] chan_err;

   logic        locked, s_locked;
   logic [5:0]  latency, s_latency;
   logic [31:0] bit_ct, err_ct, chan_ct;
   logic [3:0]  s_bit, s_err, s_chan;

   int checks = 0;
   int errors = 0;

   logic       txs[$];
   logic [6:0] lfsr = 7'h7F;

   viterbi_ber_checker dut (
      .clk(clk), .rst(rst), .tx_bit_i(tx_bit), .tx_valid_i(tx_valid),
      .rx_bit_i(rx_bit), .rx_valid_i(rx_valid), .chan_err_i(chan_err), .clear_i(clear),
      .locked_o(locked), .latency_o(latency), .bit_ct_o(bit_ct), .err_ct_o(err_ct),
      .chan_err_ct_o(chan_ct)
   );

   viterbi_ber_checker #(.CNT_W(4), .LOSS_THR(64)) dut_sat (
      .clk(clk), .rst(rst), .tx_bit_i(tx_bit), .tx_valid_i(tx_valid),
      .rx_bit_i(rx_bit), .rx_valid_i(rx_valid), .chan_err_i(chan_err), .clear_i(clear),
      .locked_o(s_locked), .latency_o(s_latency), .bit_ct_o(s_bit), .err_ct_o(s_err),
      .chan_err_ct_o(s_chan)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One stream cycle: PRBS7 tx bit, rx = tx delayed by 20 accepted bits, optional flip.
   task automatic step(input logic flip, input logic clr, input logic [1:0] ce);
      logic nb;
      nb = lfsr[6] ^ lfsr[5];
      lfsr = {lfsr[5:0], nb};
      tx_bit = nb;
      tx_valid = 1'b1;
      if (txs.size() >= 20) begin
         rx_valid = 1'b1;
         rx_bit = txs[txs.size() - 20] ^ flip;
      end else begin
         rx_valid = 1'b0;
         rx_bit = 1'b0;
      end
      txs.push_back(nb);
      clear = clr;
      chan_err = ce;
      tick();
      tx_valid = 1'b0;
      rx_valid = 1'b0;
      clear = 1'b0;
      chan_err = 2'b00;
   endtask

   task automatic wait_lock(input string tag);
      int n;
      n = 0;
      while (!locked && n < 600) begin
         step(1'b0, 1'b0, 2'b00);
         n++;
      end
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL %s_locked got %0b want 1", tag, locked); end
      checks++;
      if (latency !== 6'd19) begin errors++; $display("FAIL %s_latency got %0d want 19", tag, latency); end
      checks++;
      if (s_locked !== 1'b1) begin errors++; $display("FAIL %s_sat_locked got %0b want 1", tag, s_locked); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
      checks++;
      if (latency !== 6'd0) begin errors++; $display("FAIL reset_latency got %0d want 0", latency); end
      checks++;
      if (bit_ct !== 32'd0) begin errors++; $display("FAIL reset_bit_ct got %0d want 0", bit_ct); end
      checks++;
      if (err_ct !== 32'd0) begin errors++; $display("FAIL reset_err_ct got %0d want 0", err_ct); end
      checks++;
      if (chan_ct !== 32'd0) begin errors++; $display("FAIL reset_chan_ct got %0d want 0", chan_ct); end
   endtask

   task automatic test_chan_search();
      chan_err = 2'b10;
      repeat (5) tick();
      chan_err = 2'b11;
      repeat (3) tick();
      chan_err = 2'b00;
      checks++;
      if (chan_ct !== 32'd11) begin errors++; $display("FAIL chan_search got %0d want 11", chan_ct); end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL chan_search_locked got %0b want 0", locked); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++;
      if (chan_ct !== 32'd0) begin errors++; $display("FAIL chan_clear_search got %0d want 0", chan_ct); end
   endtask

   task automatic test_align();
      wait_lock("align");
      checks++;
      if (bit_ct !== 32'd0) begin errors++; $display("FAIL align_bit_at_lock got %0d want 0", bit_ct); end
      repeat (1000) step(1'b0, 1'b0, 2'b00);
      checks++;
      if (bit_ct !== 32'd1000) begin errors++; $display("FAIL align_bit_ct got %0d want 1000", bit_ct); end
      checks++;
      if (err_ct !== 32'd0) begin errors++; $display("FAIL align_err_ct got %0d want 0", err_ct); end
   endtask

   task automatic test_sparse();
      for (int i = 0; i < 128; i++) begin
         step((i % 32) == 0, 1'b0, 2'b00);
         if ((i % 32) == 31) begin
            checks++;
            if (err_ct !== 32'((i + 1) / 32)) begin
               errors++; $display("FAIL sparse_err_ct got %0d want %0d", err_ct, (i + 1) / 32);
            end
            checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL sparse_locked got %0b want 1", locked); end
         end
      end
      checks++;
      if (bit_ct !== 32'd1128) begin errors++; $display("FAIL sparse_bit_ct got %0d want 1128", bit_ct); end
   endtask

   task automatic test_burst();
      repeat (64) step(1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 2'b00);
         if (i == 6) begin
            checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL burst_7th_locked got %0b want 1", locked); end
         end
      end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL burst_loss got %0b want 0", locked); end
      checks++;
      if (err_ct !== 32'd12) begin errors++; $display("FAIL burst_err_ct got %0d want 12", err_ct); end
      checks++;
      if (bit_ct !== 32'd1200) begin errors++; $display("FAIL burst_bit_ct got %0d want 1200", bit_ct); end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 2'b00);
         if (i == 14) begin
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got %0b want 0", locked); end
         end
      end
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL relock got %0b want 1", locked); end
      checks++;
      if (latency !== 6'd19) begin errors++; $display("FAIL relock_latency got %0d want 19", latency); end
      checks++;
      if (bit_ct !== 32'd1200) begin errors++; $display("FAIL search_bit_ct got %0d want 1200", bit_ct); end
   endtask

   task automatic test_clear_locked();
      step(1'b1, 1'b1, 2'b11);
      checks++;
      if (bit_ct !== 32'd0) begin errors++; $display("FAIL clear_bit_ct got %0d want 0", bit_ct); end
      checks++;
      if (err_ct !== 32'd0) begin errors++; $display("FAIL clear_err_ct got %0d want 0", err_ct); end
      checks++;
      if (chan_ct !== 32'd0) begin errors++; $display("FAIL clear_chan_ct got %0d want 0", chan_ct); end
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL clear_locked got %0b want 1", locked); end
      repeat (5) step(1'b0, 1'b0, 2'b10);
      repeat (3) step(1'b0, 1'b0, 2'b11);
      checks++;
      if (chan_ct !== 32'd11) begin errors++; $display("FAIL chan_locked got %0d want 11", chan_ct); end
      checks++;
      if (bit_ct !== 32'd8) begin errors++; $display("FAIL chan_locked_bit_ct got %0d want 8", bit_ct); end
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL chan_locked_lock got %0b want 1", locked); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL rstmid_locked got %0b want 0", locked); end
      checks++;
      if (latency !== 6'd0) begin errors++; $display("FAIL rstmid_latency got %0d want 0", latency); end
      checks++;
      if (bit_ct !== 32'd0) begin errors++; $display("FAIL rstmid_bit_ct got %0d want 0", bit_ct); end
      checks++;
      if (chan_ct !== 32'd0) begin errors++; $display("FAIL rstmid_chan_ct got %0d want 0", chan_ct); end
      wait_lock("rstmid");
   endtask

   task automatic test_saturation();
      step(1'b0, 1'b1, 2'b00);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 2'b00);
         if (i == 13) begin
            checks++;
            if (s_err !== 4'd14) begin errors++; $display("FAIL sat_err_14 got %0d want 14", s_err); end
         end
         if (i == 14) begin
            checks++;
            if (s_err !== 4'd15) begin errors++; $display("FAIL sat_err_15 got %0d want 15", s_err); end
         end
      end
      checks++;
      if (s_err !== 4'd15) begin errors++; $display("FAIL sat_err_hold got %0d want 15", s_err); end
      checks++;
      if (s_bit !== 4'd15) begin errors++; $display("FAIL sat_bit_hold got %0d want 15", s_bit); end
      checks++;
      if (s_locked !== 1'b1) begin errors++; $display("FAIL sat_locked got %0b want 1", s_locked); end
      checks++;
      if (err_ct !== 32'd8) begin errors++; $display("FAIL loss_err_ct got %0d want 8", err_ct); end
      checks++;
      if (bit_ct !== 32'd8) begin errors++; $display("FAIL loss_bit_ct got %0d want 8", bit_ct); end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL loss_locked got %0b want 0", locked); end
   endtask

   initial begin
      rst = 1'b1;
      tx_bit = 1'b0;
      tx_valid = 1'b0;
      rx_bit = 1'b0;
      rx_valid = 1'b0;
      clear = 1'b0;
      chan_err = 2'b00;
      test_reset();
      test_chan_search();
      test_align();
      test_sparse();
      test_burst();
      test_clear_locked();
      test_reset_mid();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Receive-side bit-error-rate checker for the convolutional-encoder / channel / Viterbi-decoder loop. It records the bits accepted by the encoder and finds the decoder's end-to-end latency by searching for a match. Once it locks, it compares every decoded bit against the transmitted bit and counts decoded bits, decoded-bit errors and channel-injected errors. It sits beside the decoder in the tx/rx harness and is the measuring end for the channel's error-injection stage.

## Interface
- `HIST_DEPTH`, 64: transmit history depth; candidate latencies are 0..HIST_DEPTH-1.
- `SYNC_LEN`, 16: consecutive matches required to declare lock.
- `WIN_LEN`, 64: loss-of-lock observation window, in compared bits.
- `LOSS_THR`, 8: errors within one window that force loss of lock.
- `CNT_W`, 32: width of the statistics counters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_bit_i` in 1: bit presented to the encoder.
- `tx_valid_i` in 1: `tx_bit_i` accepted this cycle (the encoder enable).
- `rx_bit_i` in 1: decoder output bit.
- `rx_valid_i` in 1: `rx_bit_i` valid this cycle.
- `chan_err_i` in 2: per-symbol channel error mask (XOR pattern applied to the encoder output).
- `clear_i` in 1: zero all statistics counters; lock state is kept.
- `locked_o` out 1: alignment found.
- `latency_o` out $clog2(HIST_DEPTH): locked candidate index.
- `bit_ct_o` out CNT_W: bits compared while locked.
- `err_ct_o` out CNT_W: mismatches while locked.
- `chan_err_ct_o` out CNT_W: total set bits of `chan_err_i`, counted in every state.

## Operation
- **History.**
  - On `tx_valid_i`, `tx_bit_i` shifts into `hist[0]`, and `hist[k]` moves to `hist[k+1]`.
  - `fill` counts accepted bits and saturates at HIST_DEPTH.
  - Comparisons always use the pre-shift history. `hist[k]` is the (k+1)-th most recent bit accepted before the current cycle.
- **SEARCH** (the state after reset). Registers `cand` and `run`. On each `rx_valid_i`:
  - If `fill <= cand`: no action.
  - On a match with `hist[cand]`: `run` increments. When `run` reaches SYNC_LEN, the block moves to LOCKED, with `latency_o` = `cand` and `run` = 0.
  - On a mismatch: `run` = 0, and `cand` advances by one, wrapping from HIST_DEPTH-1 to 0.
- **LOCKED.** On each `rx_valid_i`, `rx_bit_i` is compared with `hist[latency_o]`:
  - `bit_ct_o` increments on every compare; `err_ct_o` increments on every mismatch.
  - `win_bits` and `win_errs` track the current window.
  - When `win_errs` reaches LOSS_THR, the block moves to SEARCH with `cand` = `latency_o`, `run` = 0 and the window cleared.
  - When `win_bits` reaches WIN_LEN, the window resets without loss.
- **Counters.**
  - All counters saturate at all-ones and never wrap.
  - `chan_err_ct_o` adds `chan_err_i[1] + chan_err_i[0]`, i.e. 0, 1 or 2 per cycle.
- **Simultaneous events.**
  - `clear_i` together with a count event: clear wins, and the counter becomes 0, not 1.
  - `tx_valid_i` and `rx_valid_i` in the same cycle are both processed.
  - A loss-of-lock compare is itself counted in `bit_ct_o` and `err_ct_o`.
- **`rst` in any state**: SEARCH, with `cand`, `run`, `fill`, window and all counters at 0.

## Timing
- All outputs are registered.
- Reset values: `locked_o` 0, `latency_o` 0, and all counters 0.
- Lock latency: `locked_o` rises on the edge that samples the SYNC_LEN-th consecutive match. `latency_o` updates on the same edge.
- Counters reflect a compare on the edge that samples it, i.e. one cycle of output latency.
- Loss of lock: `locked_o` falls on the edge that samples the LOSS_THR-th window error.
- No handshake back-pressure: both inputs are accepted every valid cycle.

## Structure
- **Package `viterbi_ber_pkg`:**
  - `typedef enum logic {ST_SEARCH, ST_LOCKED} ber_state_t`.
  - Default constants for HIST_DEPTH, SYNC_LEN, WIN_LEN, LOSS_THR and CNT_W.
- **Sub-module `ber_history`:**
  - Parameterised shift register.
  - Indexed combinational read port.
  - Saturating `fill` output.
- The top level holds the FSM, the window logic and the saturating counters.

## Test plan
- **Clean alignment.** Random `tx_bit_i` every cycle; `rx_bit_i` equals tx delayed by 20 cycles, with `rx_valid_i` following. Required: `locked_o` = 1 and `latency_o` = 19. After 1000 further bits: `bit_ct_o` = 1000 and `err_ct_o` = 0.
- **Sparse errors.** While locked, flip one rx bit in every 32. Required: `err_ct_o` advances 1 per 32 bits and `locked_o` stays 1 (2 errors per window, below 8).
- **Burst errors.** While locked, flip 8 consecutive rx bits. Required: `locked_o` = 0 one edge after the 8th flip; relock at `latency_o` = 19 after 16 clean bits.
- **Channel count.** Drive `chan_err_i` = 2'b10 for 5 cycles, then 2'b11 for 3 cycles. Required: `chan_err_ct_o` = 11, in both SEARCH and LOCKED.
- **Clear and saturation.** `clear_i` pulsed while locked: counters read 0 and lock is held. With CNT_W = 4, run 40 erroneous bits: `err_ct_o` holds at 15.
- **Reset mid-lock.** Assert `rst` for one cycle while locked with nonzero counts. Required: all outputs 0 after that edge; relock succeeds once the history refills.
